adder_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single registered `adder` datapath among N requesters. Captures one requester's operands, drives the adder's enable and operand inputs for exactly one cycle, collects the registered sum and returns it with a one-cycle acknowledge. Sits between the `adder` instance and the ALU-side clients. It is the only driver of the adder's enable and operand inputs.

---
 rtl/adder_arbiter.sv | 158 +++++++++++++++
 tb/tb_adder_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// Round-robin arbiter/sequencer sharing one registered adder among N requesters.
// Each grant runs IDLE -> ISSUE -> CAPTURE and returns the sum with a one-cycle ack.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module adder_arbiter #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = 2,
    parameter int unsigned W   = `DATA_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   req_op1,
    input  logic [N*W-1:0]   req_op2,
    output logic [N-1:0]     ack,
    output logic [W-1:0]     result,
    output logic [IDW-1:0]   grant_id,
    output logic             busy,
    output logic             add_enable,
    output logic [W-1:0]     add_op1,
    output logic [W-1:0]     add_op2,
    input  logic [W-1:0]     add_result
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE
    } state_t;

    localparam logic [IDW:0]   NW   = (IDW+1)'(N);
    localparam logic [IDW-1:0] LAST = IDW'(N - 1);

    state_t         r_state;
    state_t         w_next_state;
    logic [IDW-1:0] r_rr_ptr;
    logic [IDW-1:0] r_grant_id;
    logic [N-1:0]   r_ack;
    logic [W-1:0]   r_result;
    logic [W-1:0]   r_add_op1;
    logic [W-1:0]   r_add_op2;

    logic [N-1:0]   w_eligible;
    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic           w_found;
    logic [IDW-1:0] w_pick;
    logic [IDW:0]   w_sum;
    logic [W-1:0]   w_sel_op1;
    logic [W-1:0]   w_sel_op2;
    logic           w_busy;
    logic           w_add_enable;

    // A requester whose ack is still high is finishing; it must not be re-granted.
    assign w_eligible = req & ~r_ack;
    assign w_dbl      = {w_eligible, w_eligible};
    assign w_rot      = N'(w_dbl >> r_rr_ptr);

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_sum   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_rr_ptr} + (IDW+1)'(k);
                if (w_sum >= NW) begin
                    w_sum = w_sum - NW;
                end
                w_pick = w_sum[IDW-1:0];
            end
        end
    end

    always_comb begin
        w_sel_op1 = '0;
        w_sel_op2 = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (w_pick == IDW'(k)) begin
                w_sel_op1 = req_op1[k*W +: W];
                w_sel_op2 = req_op2[k*W +: W];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b0;
        w_add_enable = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_busy       = 1'b1;
                w_add_enable = 1'b1;
                w_next_state = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                w_busy       = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_ack      <= '0;
            r_result   <= '0;
            r_add_op1  <= '0;
            r_add_op2  <= '0;
        end else begin
            r_ack <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant_id <= w_pick;
                        r_add_op1  <= w_sel_op1;
                        r_add_op2  <= w_sel_op2;
                    end
                end
                ST_CAPTURE: begin
                    r_result <= add_result;
                    r_ack    <= N'(1) << r_grant_id;
                    r_rr_ptr <= (r_grant_id == LAST) ? '0 : r_grant_id + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign ack        = r_ack;
    assign result     = r_result;
    assign grant_id   = r_grant_id;
    assign busy       = w_busy;
    assign add_enable = w_add_enable;
    assign add_op1    = r_add_op1;
    assign add_op2    = r_add_op2;

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: stimulus queues expected acks/sums, a monitor
// pops and compares on every ack pulse. A behavioural registered adder closes the loop.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module tb_adder_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned IDW = 2;
    localparam int unsigned W   = `DATA_WIDTH;

    logic             clock = 1'b0;
    logic             reset;
    logic [N-1:0]     req;
    logic [N*W-1:0]   req_op1;
    logic [N*W-1:0]   req_op2;
    logic [N-1:0]     ack;
    logic [W-1:0]     result;
    logic [IDW-1:0]   grant_id;
    logic             busy;
    logic             add_enable;
    logic [W-1:0]     add_op1;
    logic [W-1:0]     add_op2;
    logic [W-1:0]     add_result = '0;

    typedef struct {
        logic [N-1:0] ack;
        logic [W-1:0] res;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    adder_arbiter #(.N(N), .IDW(IDW), .W(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .req_op1    (req_op1),
        .req_op2    (req_op2),
        .ack        (ack),
        .result     (result),
        .grant_id   (grant_id),
        .busy       (busy),
        .add_enable (add_enable),
        .add_op1    (add_op1),
        .add_op2    (add_op2),
        .add_result (add_result)
    );

    always #5 clock = ~clock;

    // Stand-in for the shared adder: registers the sum when enabled, no reset.
    always @(posedge clock) begin
        if (add_enable) add_result <= add_op1 + add_op2;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (reset === 1'b1 && ack !== '0) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", 64'(ack), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_ack", 64'(ack), 64'(e.ack));
                check("sb_result", 64'(result), 64'(e.res));
            end
        end
    end

    task automatic expect_op(input int i, input logic [W-1:0] r);
        exp_t e;
        e.ack = N'(1) << i;
        e.res = r;
        sb.push_back(e);
    endtask

    task automatic set_slot(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_op1[i*W +: W] = a;
        req_op2[i*W +: W] = b;
    endtask

    // Waits for ack[i] within a bounded budget, then drops req[i] like a real requester.
    task automatic wait_ack(input int i, input int exp_cyc, input string name);
        int c;
        bit seen;
        c = 0;
        seen = 1'b0;
        while (!seen && c < 20) begin
            @(negedge clock);
            c++;
            if (ack[i]) seen = 1'b1;
        end
        req[i] = 1'b0;
        check(name, 64'(c), 64'(exp_cyc));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ack"},        64'(ack),        64'(0));
        check({tag, "_result"},     64'(result),     64'(0));
        check({tag, "_grant_id"},   64'(grant_id),   64'(0));
        check({tag, "_busy"},       64'(busy),       64'(0));
        check({tag, "_add_enable"}, 64'(add_enable), 64'(0));
        check({tag, "_add_op1"},    64'(add_op1),    64'(0));
        check({tag, "_add_op2"},    64'(add_op2),    64'(0));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        req     = '0;
        req_op1 = '0;
        req_op2 = '0;
        repeat (3) @(negedge clock);
        check_reset_values("rst");
        reset = 1'b1;
        @(negedge clock);

        // Single request on slot 2: 5 + 7
        set_slot(2, W'(5), W'(7));
        req[2] = 1'b1;
        expect_op(2, W'(12));
        @(negedge clock);
        check("single_t1_enable", 64'(add_enable), 64'(1));
        check("single_t1_busy",   64'(busy),       64'(1));
        check("single_t1_grant",  64'(grant_id),   64'(2));
        check("single_t1_op1",    64'(add_op1),    64'(5));
        check("single_t1_op2",    64'(add_op2),    64'(7));
        @(negedge clock);
        check("single_t2_enable", 64'(add_enable), 64'(0));
        check("single_t2_busy",   64'(busy),       64'(1));
        @(negedge clock);
        check("single_t3_ack",    64'(ack),        64'(4'b0100));
        check("single_t3_busy",   64'(busy),       64'(0));
        check("single_t3_enable", 64'(add_enable), 64'(0));
        req[2] = 1'b0;
        @(negedge clock);
        check("single_t4_ack", 64'(ack), 64'(0));

        // Contention from rr_ptr=0: order 0,1,2,3, three cycles apart
        do_reset();
        set_slot(0, W'(10), W'(1));
        set_slot(1, W'(20), W'(2));
        set_slot(2, W'(30), W'(3));
        set_slot(3, W'(40), W'(4));
        req = 4'b1111;
        expect_op(0, W'(11));
        expect_op(1, W'(22));
        expect_op(2, W'(33));
        expect_op(3, W'(44));
        wait_ack(0, 3, "cont_lat0");
        wait_ack(1, 3, "cont_lat1");
        wait_ack(2, 3, "cont_lat2");
        wait_ack(3, 3, "cont_lat3");

        // rr_ptr back to 0: requesters 1 and 0 together, 0 wins
        req[1:0] = 2'b11;
        expect_op(0, W'(11));
        expect_op(1, W'(22));
        wait_ack(0, 3, "pair_lat0");
        wait_ack(1, 3, "pair_lat1");

        // Serve 3 alone so rr_ptr wraps to 0, then 3 and 0 together: 0 first
        req[3] = 1'b1;
        expect_op(3, W'(44));
        wait_ack(3, 3, "wrap_pre_lat3");
        req[3] = 1'b1;
        req[0] = 1'b1;
        expect_op(0, W'(11));
        expect_op(3, W'(44));
        wait_ack(0, 3, "wrap_lat0");
        wait_ack(3, 3, "wrap_lat3");

        // Overflow wraps to zero
        set_slot(1, '1, W'(1));
        req[1] = 1'b1;
        expect_op(1, W'(0));
        wait_ack(1, 3, "ovf_lat1");

        // Operand change after sampling must not affect the result
        set_slot(3, W'(10), W'(20));
        req[3] = 1'b1;
        expect_op(3, W'(30));
        @(negedge clock);
        req_op1[3*W +: W] = W'(99);
        check("opchg_issue_op1", 64'(add_op1), 64'(10));
        wait_ack(3, 2, "opchg_lat3");

        // Request dropped during ISSUE still completes with an ack
        set_slot(0, W'(10), W'(1));
        req[0] = 1'b1;
        expect_op(0, W'(11));
        @(negedge clock);
        req[0] = 1'b0;
        wait_ack(0, 2, "drop_lat0");

        // Reset during CAPTURE: immediate reset values, no ack, clean re-request
        set_slot(2, W'(5), W'(7));
        req[2] = 1'b1;
        repeat (2) @(negedge clock);
        check("midrst_capture_busy", 64'(busy), 64'(1));
        reset = 1'b0;
        #1;
        check_reset_values("midrst");
        req[2] = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (5) @(negedge clock);
        req[2] = 1'b1;
        expect_op(2, W'(12));
        wait_ack(2, 3, "midrst_rereq_lat2");

        repeat (4) @(negedge clock);
        check("sb_drained", 64'(sb.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
